sram_bus_arbiter: RTL and testbench

//  Shares one single-port request/ack memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/sram_bus_arbiter_pkg.sv | 15 +
 rtl/sram_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package sram_bus_arbiter_pkg;

    // Arbiter bus-cycle owner: nobody, the fetch stage, or the data stage.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_e;

    // Bit positions inside the ctrl stall vector.
    localparam int ARB_STALL_IF  = 1;   // IF/ID register held
    localparam int ARB_STALL_MEM = 4;   // MEM/WB register held

endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates one single-port req/ack memory bus between instruction fetch and
// load/store. Data accesses beat fetches; completed read data is held in
// registers until the owning pipeline stage advances.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int SEL_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stallreq_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    arb_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              i_done_q, i_done_d;     // fetch result waiting for IF/ID to advance
    logic              d_done_q, d_done_d;     // data result waiting for MEM/WB to advance
    logic              i_discard_q, i_discard_d; // in-flight fetch was flushed, drop its data

    // Next-state logic: done-flag aging, arbitration in IDLE, ack handling.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        i_discard_d = i_discard_q;

        // A held result is released once its stage moves on. Setting on an
        // ack below takes precedence so a fresh result is never lost.
        if (!stall_i[ARB_STALL_MEM]) begin
            d_done_d = 1'b0;
        end
        if (!stall_i[ARB_STALL_IF] || flush_i) begin
            i_done_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                // bus_ack_i is deliberately ignored here (late ack after reset).
                if (mem_ce_i && !d_done_q) begin
                    state_d     = ARB_D_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_data_i;
                end else if (if_ce_i && !i_done_q && !flush_i) begin
                    state_d    = ARB_I_BUSY;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = {SEL_W{1'b1}};
                    bus_addr_d = if_addr_i;
                end
            end
            ARB_I_BUSY: begin
                if (bus_ack_i) begin
                    // A flush landing on the ack edge also kills this fetch.
                    if (!i_discard_q && !flush_i) begin
                        if_data_d = bus_rdata_i;
                        i_done_d  = 1'b1;
                    end
                    i_discard_d = 1'b0;
                    bus_req_d   = 1'b0;
                    state_d     = ARB_IDLE;
                end else if (flush_i) begin
                    // The slave cannot abort, so let the cycle finish and drop it.
                    i_discard_d = 1'b1;
                end
            end
            ARB_D_BUSY: begin
                if (bus_ack_i) begin
                    if (!bus_we_q) begin
                        mem_data_d = bus_rdata_i;
                    end
                    d_done_d  = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_discard_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_discard_q <= i_discard_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;

    // Stall requests are combinational so ctrl freezes the pipe in the same cycle.
    assign if_stallreq_o  = if_ce_i & ~i_done_q & ~flush_i;
    assign mem_stallreq_o = mem_ce_i & ~d_done_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized scoreboard bench for sram_bus_arbiter: a reference memory predicts
// bus cycles and returned data; a slave model answers the bus; monitors compare.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_stallreq_o(if_stallreq_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_stallreq_o(mem_stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        b2b;   // must issue the cycle right after the previous ack
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] ref_mem[256];
    logic [31:0] slv_mem[256];
    logic [31:0] last_load;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ack_cyc = -10;
    int          force_lat = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: checks each new cycle against the predicted order, checks the
    // request fields stay stable, then acks after a random latency.
    initial begin : slave
        bus_exp_t    cur;
        logic        serving;
        int          lat;
        logic [7:0]  idx;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        serving     = 1'b0;
        lat         = 0;
        idx         = '0;
        cur         = '0;
        forever begin
            @(negedge clk);
            if (bus_ack_i) begin
                bus_ack_i    = 1'b0;
                bus_rdata_i  = '0;
                serving      = 1'b0;
                last_ack_cyc = cyc;
            end else begin
                if (!serving && bus_req_o) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_req", 32'd1, 32'd0);
                        cur = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, 1'b0};
                    end else begin
                        cur = bus_q.pop_front();
                        if (cur.b2b) chk("bus_b2b_issue", cyc, last_ack_cyc + 1);
                    end
                    serving = 1'b1;
                    lat     = (force_lat >= 0) ? force_lat : $urandom_range(0, 2);
                    idx     = cur.addr[9:2];
                end
                if (serving) begin
                    if (bus_req_o) begin
                        chk("bus_addr", bus_addr_o, cur.addr);
                        chk("bus_we", {31'd0, bus_we_o}, {31'd0, cur.we});
                        chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, cur.sel});
                        if (cur.we) chk("bus_wdata", bus_wdata_o, cur.wdata);
                    end
                    if (lat == 0) begin
                        bus_ack_i   = 1'b1;
                        bus_rdata_i = slv_mem[idx];
                        if (bus_req_o && bus_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (bus_sel_o[b]) slv_mem[bus_addr_o[9:2]][8*b +: 8] = bus_wdata_o[8*b +: 8];
                        end
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    // Result monitor: when a stage's stall request falls, its data is ready.
    initial begin : monitor
        logic prev_if, prev_mem;
        prev_if  = 1'b0;
        prev_mem = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_if  = 1'b0;
                prev_mem = 1'b0;
            end else begin
                if (prev_if && !if_stallreq_o && if_ce_i && !flush_i) begin
                    if (if_q.size() == 0) chk("if_data_unexpected", 32'd1, 32'd0);
                    else chk("if_data", if_data_o, if_q.pop_front());
                end
                if (prev_mem && !mem_stallreq_o && mem_ce_i) begin
                    if (mem_q.size() == 0) chk("mem_data_unexpected", 32'd1, 32'd0);
                    else chk("mem_data", mem_data_o, mem_q.pop_front());
                end
                prev_if  = if_stallreq_o;
                prev_mem = mem_stallreq_o;
            end
        end
    end

    // Stall the pipe while any request is pending, optionally hold afterwards,
    // then let the stages advance and drop the enables.
    task automatic wait_done(input int hold, input bit has_if, input logic [31:0] exp_if);
        int n = 0;
        forever begin
            #1;
            if (!(if_stallreq_o || mem_stallreq_o)) break;
            stall_i = 6'b011111;
            n++;
            if (n > 60) begin
                chk("done_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
        for (int h = 0; h < hold; h++) begin
            stall_i = 6'b011111;
            @(negedge clk);
            #1;
            chk("hold_no_reissue", {31'd0, bus_req_o}, 32'd0);
            if (has_if) chk("hold_if_data", if_data_o, exp_if);
        end
        stall_i = 6'b000000;
        @(negedge clk);
        if_ce_i  = 1'b0;
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 load+fetch, 4 store+fetch
    task automatic do_txn(input int kind, input int hold, input logic [31:0] ia,
                          input logic [31:0] ma, input logic [3:0] sel, input logic [31:0] wd);
        bit has_if  = (kind == 0 || kind >= 3);
        bit has_mem = (kind != 0);
        bit is_st   = (kind == 2 || kind == 4);
        logic [31:0] exp_if = '0;
        if (has_mem) begin
            bus_q.push_back({is_st, sel, ma, wd, 1'b0});
            if (is_st) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[ma[9:2]][8*b +: 8] = wd[8*b +: 8];
                mem_q.push_back(last_load);
            end else begin
                last_load = ref_mem[ma[9:2]];
                mem_q.push_back(last_load);
            end
        end
        if (has_if) begin
            exp_if = ref_mem[ia[9:2]];
            bus_q.push_back({1'b0, 4'hF, ia, 32'd0, has_mem});
            if_q.push_back(exp_if);
        end
        @(negedge clk);
        if_ce_i    = has_if;
        if_addr_i  = ia;
        mem_ce_i   = has_mem;
        mem_we_i   = is_st;
        mem_sel_i  = sel;
        mem_addr_i = ma;
        mem_data_i = wd;
        $display("txn kind=%0d hold=%0d if_addr=%08h mem_addr=%08h sel=%h wdata=%08h",
                 kind, hold, ia, ma, sel, wd);
        wait_done(hold, has_if, exp_if);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, {31'd0, bus_req_o}, 32'd0);
        chk({tag, "_bus_we"}, {31'd0, bus_we_o}, 32'd0);
        chk({tag, "_bus_sel"}, {28'd0, bus_sel_o}, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_if_data"}, if_data_o, 32'd0);
        chk({tag, "_mem_data"}, mem_data_o, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] v;
        rst = 1'b1; stall_i = '0; flush_i = 1'b0;
        if_ce_i = 1'b0; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
        last_load = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        ref_mem[64] = 32'h3401_1100; slv_mem[64] = 32'h3401_1100;  // 0x100
        ref_mem[65] = 32'hFFFF_FFFF; slv_mem[65] = 32'hFFFF_FFFF;  // 0x104
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        chk("rst_if_stallreq", {31'd0, if_stallreq_o}, 32'd0);
        rst = 1'b0;

        // Fetch only, slow slave.
        force_lat = 2;
        do_txn(0, 0, 32'h0000_0100, 32'h0, 4'h0, 32'h0);
        force_lat = -1;
        // Conflict: load and fetch together.
        do_txn(3, 0, 32'h0000_0100, 32'h0000_0040, 4'hF, 32'h0);
        // Partial store.
        do_txn(2, 0, 32'h0, 32'h0000_0080, 4'b0011, 32'hDEAD_BEEF);
        // Read back the stored word.
        do_txn(1, 0, 32'h0, 32'h0000_0080, 4'hF, 32'h0);

        // Flush while a fetch is in flight.
        bus_q.push_back({1'b0, 4'hF, 32'h0000_0104, 32'd0, 1'b0});
        bus_q.push_back({1'b0, 4'hF, 32'h0000_0200, 32'd0, 1'b1});
        if_q.push_back(ref_mem[8'h80]);
        force_lat = 3;
        @(negedge clk);
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0104;
        $display("txn flush fetch 00000104 then 00000200");
        #1 stall_i = 6'b011111;
        @(negedge clk);
        flush_i = 1'b1; if_addr_i = 32'h0000_0200; stall_i = 6'b000000;
        @(negedge clk);
        flush_i = 1'b0; force_lat = -1;
        wait_done(0, 1'b1, ref_mem[8'h80]);

        // Hold: result stays put while IF/ID is frozen.
        do_txn(0, 3, 32'h0000_0300, 32'h0, 4'h0, 32'h0);
        do_txn(4, 2, 32'h0000_0104, 32'h0000_0104, 4'b1100, 32'h1234_5678);

        // Reset in the middle of a data cycle; the late ack must be ignored.
        bus_q.push_back({1'b0, 4'hF, 32'h0000_0040, 32'd0, 1'b0});
        force_lat = 4;
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h40;
        $display("txn reset during load 00000040");
        #1 stall_i = 6'b011111;
        @(negedge clk);
        #1 rst = 1'b1; mem_ce_i = 1'b0; stall_i = '0;
        @(negedge clk);
        force_lat = -1;
        #1 rst = 1'b0;
        check_reset_outputs("midrst");
        last_load = '0;
        repeat (6) @(negedge clk);
        #1;
        chk("late_ack_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("late_ack_mem_data", mem_data_o, 32'd0);
        chk("late_ack_stallreq", {31'd0, mem_stallreq_o}, 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            do_txn($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                   {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                   4'($urandom_range(1, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
